sonar_responder: RTL

SONAR_RESPONDER -- requirements
Module: sonar_responder

---
 rtl/sonar_pkg.sv | 23 ++
 rtl/sonar_sync2.sv | 27 ++
 rtl/sonar_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sonar_pkg
// Purpose : State encoding and default timing constants for sonar_responder.
// Revision: 1.0 - initial release
// ============================================================================
package sonar_pkg;

    localparam int unsigned MIN_TRIG_CYCLES = 500;
    localparam int unsigned BURST_DELAY     = 25000;
    localparam int unsigned HOLDOFF_CYCLES  = 1000000;
    localparam int unsigned TIMEOUT_CYCLES  = 1900000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG_HIGH = 3'd1,
        S_ARM       = 3'd2,
        S_ECHO      = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

endpackage : sonar_pkg
`default_nettype wire

// File: rtl/sonar_sync2.sv
`default_nettype none
// ============================================================================
// Module  : sonar_sync2
// Purpose : Two-flop synchronizer for the asynchronous trigger input.
// Revision: 1.0 - initial release
// ============================================================================
module sonar_sync2 (
    input  logic clk,
    input  logic reset_l,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule : sonar_sync2
`default_nettype wire

// File: rtl/sonar_responder.sv
`default_nettype none
// ============================================================================
// Module  : sonar_responder
// Purpose : Emulates an ultrasonic sensor: qualifies a trigger pulse, waits
//           a burst delay, then emits an echo of programmable length.
//           Optional macro SONAR_RESP_TIMEOUT_EN: zero length gives a
//           no-target echo of TIMEOUT_CYCLES.
// Revision: 1.0 - initial release
// ============================================================================
module sonar_responder #(
`ifdef SONAR_RESP_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES  = sonar_pkg::TIMEOUT_CYCLES,
`endif
    parameter int unsigned MIN_TRIG_CYCLES = sonar_pkg::MIN_TRIG_CYCLES,
    parameter int unsigned BURST_DELAY     = sonar_pkg::BURST_DELAY,
    parameter int unsigned HOLDOFF_CYCLES  = sonar_pkg::HOLDOFF_CYCLES
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        trigger,
    input  logic [31:0] write_data,
    input  logic        write_valid,
    output logic        echo,
    output logic        busy,
    output logic [15:0] pulse_count
);

    import sonar_pkg::*;

    // Where ARM goes, and what the counter loads, when the active length is 0.
`ifdef SONAR_RESP_TIMEOUT_EN
    localparam state_t      c_zero_next = S_ECHO;
    localparam logic [31:0] c_zero_load = TIMEOUT_CYCLES - 1;
`else
    localparam state_t      c_zero_next = S_HOLDOFF;
    localparam logic [31:0] c_zero_load = HOLDOFF_CYCLES - 1;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic        w_trig_s;
    logic [31:0] r_cnt;
    logic [31:0] r_len;
    logic [31:0] r_act_len;

    sonar_sync2 u_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .d       (trigger),
        .q       (w_trig_s)
    );

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_trig_s) w_next_state = S_TRIG_HIGH;
            S_TRIG_HIGH: if (!w_trig_s)
                             w_next_state = (r_cnt >= MIN_TRIG_CYCLES) ? S_ARM : S_IDLE;
            S_ARM:       if (r_cnt == 32'd0)
                             w_next_state = (r_act_len != 32'd0) ? S_ECHO : c_zero_next;
            S_ECHO:      if (r_cnt == 32'd0) w_next_state = S_HOLDOFF;
            S_HOLDOFF:   if (r_cnt == 32'd0) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_ARM) || (r_state == S_ECHO) || (r_state == S_HOLDOFF);
    end

    // Single down/up counter: trigger width, burst delay, echo length, holdoff.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_cnt       <= 32'd0;
            r_len       <= 32'd0;
            r_act_len   <= 32'd0;
            echo        <= 1'b0;
            pulse_count <= 16'd0;
        end else begin
            echo <= (w_next_state == S_ECHO);
            if (write_valid) r_len <= write_data;
            if (r_state != S_ECHO && w_next_state == S_ECHO)
                pulse_count <= pulse_count + 16'd1;
            case (r_state)
                S_IDLE: r_cnt <= w_trig_s ? 32'd1 : 32'd0;
                S_TRIG_HIGH: begin
                    if (w_trig_s) begin
                        if (r_cnt < MIN_TRIG_CYCLES) r_cnt <= r_cnt + 32'd1;
                    end else if (r_cnt >= MIN_TRIG_CYCLES) begin
                        r_cnt     <= BURST_DELAY - 1;
                        r_act_len <= r_len;
                    end else begin
                        r_cnt <= 32'd0;
                    end
                end
                S_ARM: begin
                    if (r_cnt != 32'd0)          r_cnt <= r_cnt - 32'd1;
                    else if (r_act_len != 32'd0) r_cnt <= r_act_len - 32'd1;
                    else                         r_cnt <= c_zero_load;
                end
                S_ECHO:    r_cnt <= (r_cnt != 32'd0) ? r_cnt - 32'd1 : HOLDOFF_CYCLES - 1;
                S_HOLDOFF: r_cnt <= (r_cnt != 32'd0) ? r_cnt - 32'd1 : 32'd0;
                default:   r_cnt <= 32'd0;
            endcase
        end
    end

endmodule : sonar_responder
`default_nettype wire
